uart_hex_rx: RTL

- UART receiver that turns a stream of ASCII hex characters back into bytes. It is the receive-side counterpart of the ADC reporting path, which transmits each byte as two ASCII hex digits, low nibble first, with no delimiter.
- Samples the serial line, decodes each 8N1 character, validates it as a hex digit and pairs consecutive digits into one byte.
- Used as a host-command input and as a loop-back checker for the ADC UART stream.

---
 rtl/uart_hex_rx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver that rebuilds bytes from pairs of ASCII hex
// digits, low nibble first, no delimiter between characters.
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   sel        baud select, 0 = BIT_CNT0 clk/bit, 1 = BIT_CNT1 clk/bit
//   rxd        serial input, asynchronous to clk
//   rx_data    last assembled byte {high nibble, low nibble}
//   rx_valid   one-cycle pulse, rx_data just updated
//   pending    a low nibble is held, waiting for its high nibble
//   busy       receiver FSM is not idle
//   frame_err  one-cycle pulse, stop bit sampled low
//   char_err   one-cycle pulse, framed character is not a hex digit
module uart_hex_rx #(
   parameter int BIT_CNT0     = 5208,
   parameter int BIT_CNT1     = 434,
   parameter bit RX_INVERT    = 1'b0,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       sel,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       pending,
   output logic       busy,
   output logic       frame_err,
   output logic       char_err
);

   localparam int MAXN = (BIT_CNT0 > BIT_CNT1) ? BIT_CNT0 : BIT_CNT1;
   localparam int CW   = $clog2(MAXN + 1);
   localparam int TW   = $clog2(MAXN * TIMEOUT_BITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state, state_nx;

   logic [1:0]    sync_q;
   logic          line, line_q, armed, start_det, start_go;
   logic          smp_start, smp_data, smp_stop;
   logic [CW-1:0] n_q, cnt, half, last;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [3:0]    nib;
   logic          dig_ok;
   logic [3:0]    dig;
   logic [TW-1:0] to_cnt, to_lim;
   logic          to_expire;

   // {valid, value} for an ASCII hex digit
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      r = 5'h00;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, c[3:0]};
      else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

   // Synchronizer resets to the value that reads as a low line, so the
   // receiver cannot arm until real idle level has been seen.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= {2{RX_INVERT}};
         line_q <= 1'b0;
         armed  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rxd};
         line_q <= line;
         armed  <= armed | line;
      end
   end

   assign line      = sync_q[1] ^ RX_INVERT;
   assign start_det = armed & line_q & ~line;
   assign half      = n_q >> 1;
   assign last      = n_q - CW'(1);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      smp_start = 1'b0;
      smp_data  = 1'b0;
      smp_stop  = 1'b0;
      unique case (state)
         IDLE:  if (start_det) state_nx = START;
         START: if (cnt == half) begin
                   smp_start = 1'b1;
                   // high at mid start bit is a glitch, drop silently
                   state_nx  = line ? IDLE : DATA;
                end
         DATA:  if (cnt == last) begin
                   smp_data = 1'b1;
                   if (bit_idx == 3'd7) state_nx = STOP;
                end
         STOP:  if (cnt == last) begin
                   smp_stop = 1'b1;
                   // a start edge coinciding with the return to idle is kept
                   state_nx = start_det ? START : IDLE;
                end
         default: state_nx = IDLE;
      endcase
   end

   assign start_go = (state_nx == START) && (state != START);

   // Bit timing: cnt restarts at every start and every sample point.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt     <= '0;
         n_q     <= CW'(BIT_CNT0);
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         if (start_go || smp_start || smp_data || smp_stop || state == IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (start_go) begin
            n_q     <= sel ? CW'(BIT_CNT1) : CW'(BIT_CNT0);
            bit_idx <= 3'd0;
         end else if (smp_data) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (smp_data) shreg <= {line, shreg[7:1]};
      end
   end

   assign {dig_ok, dig} = hex_decode(shreg);

   // Orphan low nibble timeout, counted only while idle.
   assign to_lim    = TW'(TIMEOUT_BITS) * TW'(n_q);
   assign to_expire = pending && (state == IDLE) && !start_det &&
                      (to_cnt == to_lim - TW'(1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         to_cnt <= '0;
      else if (!pending || start_go || to_expire)
         to_cnt <= '0;
      else if (state == IDLE)
         to_cnt <= to_cnt + TW'(1);
   end

   // Character acceptance and nibble pairing; pulses land one cycle after
   // the stop sample.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         char_err  <= 1'b0;
         pending   <= 1'b0;
         nib       <= 4'h0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         char_err  <= 1'b0;
         if (smp_stop) begin
            if (!line) begin
               frame_err <= 1'b1;
               pending   <= 1'b0;
            end else if (!dig_ok) begin
               char_err <= 1'b1;
               pending  <= 1'b0;
            end else if (pending) begin
               rx_data  <= {dig, nib};
               rx_valid <= 1'b1;
               pending  <= 1'b0;
            end else begin
               nib     <= dig;
               pending <= 1'b1;
            end
         end else if (to_expire) begin
            pending <= 1'b0;
         end
      end
   end

endmodule
